// File: rtl/conv1_weight_stream.sv
// conv1_weight_stream: captures the packed conv1 weight word and streams it one weight per
// valid/ready transfer, tagged with flat index, kernel number and end-of-kernel/set markers.
module conv1_weight_stream #(
  parameter int WEIGHT_NUM  = 18,
  parameter int DATA_WIDTH  = 16,
  parameter int KERNEL_SIZE = 9,
  parameter int IDX_W       = 5,
  parameter int KER_W       = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             load,
  input  logic [WEIGHT_NUM*DATA_WIDTH-1:0] w_bus,
  output logic                             busy,
  output logic                             w_valid,
  input  logic                             w_ready,
  output logic [DATA_WIDTH-1:0]            w_data,
  output logic [IDX_W-1:0]                 w_index,
  output logic [KER_W-1:0]                 w_kernel,
  output logic                             w_last_tap,
  output logic                             w_last,
  output logic                             done
);
  localparam int TAP_W = (KERNEL_SIZE > 1) ? $clog2(KERNEL_SIZE) : 1;
  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;
  state_t                          state_q, state_d;
  logic [WEIGHT_NUM*DATA_WIDTH-1:0] hold_q, hold_d;
  logic [IDX_W-1:0]                idx_q, idx_d;
  logic [TAP_W-1:0]                tap_q, tap_d;
  logic [KER_W-1:0]                ker_q, ker_d;
  logic                            tap_end, idx_end;
  assign tap_end    = tap_q == TAP_W'(KERNEL_SIZE - 1);
  assign idx_end    = idx_q == IDX_W'(WEIGHT_NUM - 1);
  assign busy       = state_q != IDLE;
  assign w_valid    = state_q == STREAM;
  assign done       = state_q == DONE;
  assign w_data     = hold_q[32'(idx_q) * DATA_WIDTH +: DATA_WIDTH];
  assign w_index    = idx_q;
  assign w_kernel   = ker_q;
  assign w_last_tap = tap_end;
  assign w_last     = idx_end;
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    idx_d   = idx_q;
    tap_d   = tap_q;
    ker_d   = ker_q;
    if (state_q == IDLE && load) begin
      state_d = STREAM;
      hold_d  = w_bus;
      idx_d   = '0;
      tap_d   = '0;
      ker_d   = '0;
    end else if (state_q == STREAM && w_ready) begin
      // counters freeze on the final transfer so tags hold their last values in IDLE
      state_d = idx_end ? DONE : STREAM;
      idx_d   = idx_end ? idx_q : idx_q + 1'b1;
      tap_d   = idx_end ? tap_q : (tap_end ? '0 : tap_q + 1'b1);
      ker_d   = (!idx_end && tap_end) ? ker_q + 1'b1 : ker_q;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      hold_q  <= '0;
      idx_q   <= '0;
      tap_q   <= '0;
      ker_q   <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      idx_q   <= idx_d;
      tap_q   <= tap_d;
      ker_q   <= ker_d;
    end
  end
endmodule
